// File: rtl/regfile_arb.sv
// Register file and decode stage: rs/rt/rd/imm decode, two read ports plus debug, core writeback,
// post-reset clear sequence and an arbitrated external write port. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_arb #(
    parameter int DATA_W       = 32,
    parameter int EXT_MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] opcplus4,
    input  logic              jal,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              reg_dst,
    input  logic              ext_wr_req,
    input  logic [4:0]        ext_wr_addr,
    input  logic [DATA_W-1:0] ext_wr_data,
    output logic              ext_wr_ack,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] imme_extend,
    output logic [DATA_W-1:0] last_wr_data,
    output logic              busy,
    output logic              core_stall
);

    // state | meaning
    // CLEAR | zeroing one register per cycle after reset; reads 0, writes ignored
    // RUN   | normal operation with core/external write arbitration
    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    localparam int WAIT_W = $clog2(EXT_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(EXT_MAX_WAIT);

    state_t            state;
    logic [4:0]        clr_idx;
    logic [WAIT_W-1:0] wait_left;
    logic [DATA_W-1:0] regs [32];

    logic [5:0]        opcode;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic              running, core_we, req_eff, preempt, ext_go, core_go, wr_en;
    logic [4:0]        core_addr, wr_addr;
    logic [DATA_W-1:0] core_data, wr_data;

    assign opcode = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign imm    = instruction[15:0];

    assign running   = (state == RUN);
    assign core_we   = reg_write || jal;
    assign core_addr = (jal && opcode == 6'b000011) ? 5'd31 : (reg_dst ? rd : rt);
    assign core_data = jal ? opcplus4 : (mem_to_reg ? read_data : alu_result);

    // A request in its own ack cycle is treated as absent, so it can never be double-granted.
    assign req_eff    = running && ext_wr_req && !ext_wr_ack;
    assign preempt    = req_eff && core_we && (wait_left == '0);
    assign ext_go     = req_eff && (!core_we || (wait_left == '0));
    assign core_go    = running && core_we && !preempt;
    assign core_stall = preempt;

    assign wr_en   = (core_go && core_addr != 5'd0) || (ext_go && ext_wr_addr != 5'd0);
    assign wr_addr = ext_go ? ext_wr_addr : core_addr;
    assign wr_data = ext_go ? ext_wr_data : core_data;

    function automatic logic [DATA_W-1:0] rd_port(
        input logic [4:0]        a,
        input logic [DATA_W-1:0] stored,
        input logic              run,
        input logic              wen,
        input logic [4:0]        waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] v;
        v = stored;
`ifdef REGFILE_BYPASS_EN
        if (wen && waddr == a) v = wdata;
`else
        if (wen && waddr == a && 1'b0) v = wdata;
`endif
        if (!run || a == 5'd0) v = '0;
        return v;
    endfunction

    assign read_data_1 = rd_port(rs, regs[rs], running, wr_en, wr_addr, wr_data);
    assign read_data_2 = rd_port(rt, regs[rt], running, wr_en, wr_addr, wr_data);
    assign dbg_data    = rd_port(dbg_addr, regs[dbg_addr], running, wr_en, wr_addr, wr_data);

    assign imme_extend = (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E)
                       ? {{(DATA_W-16){1'b0}}, imm}
                       : {{(DATA_W-16){imm[15]}}, imm};

    assign busy = (state == CLEAR);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= CLEAR;
            clr_idx      <= 5'd0;
            wait_left    <= WAIT_INIT;
            ext_wr_ack   <= 1'b0;
            last_wr_data <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[clr_idx] <= '0;
                    clr_idx       <= clr_idx + 5'd1;
                    ext_wr_ack    <= 1'b0;
                    wait_left     <= WAIT_INIT;
                    if (clr_idx == 5'd31) state <= RUN;
                end
                RUN: begin
                    ext_wr_ack <= ext_go;
                    if (wr_en) regs[wr_addr] <= wr_data;
                    if (core_go && core_addr != 5'd0) last_wr_data <= core_data;
                    // Deferral budget counts down only while a live request loses to the core.
                    if (req_eff && !ext_go) wait_left <= wait_left - WAIT_W'(1);
                    else                    wait_left <= WAIT_INIT;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule
